// File: rtl/tt_gpio_cfg_seq_if.sv
// Shadow-write channel of the GPIO configuration sequencer.
//   wr_valid : host write request (held by the host until wr_ready)
//   wr_ready : sequencer accepts the write on wr_valid && wr_ready
//   wr_addr  : target pad index (ignored when wr_all is set)
//   wr_all   : broadcast wr_data to every shadow entry
//   wr_data  : configuration word
// master = host side, slave = sequencer side.
interface tt_gpio_cfg_seq_if #(
  parameter int unsigned AW    = 6,
  parameter int unsigned CFG_W = 16
);
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic             wr_all;
  logic [CFG_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_all,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_all,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/tt_gpio_cfg_seq.sv
// GPIO pad configuration sequencer.
// The host fills a shadow bank through the write channel; a commit copies the
// shadow bank into the active bank one pad per cycle (staggered so the pads
// do not all switch on the same edge). The active bank drives the pad cells.
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset (both banks -> DEFAULT_CONFIG)
//   wr         : shadow write channel (slave side)
//   commit     : start the shadow-to-active sweep (IDLE only)
//   revert     : reload the shadow bank from DEFAULT_CONFIG (IDLE only)
//   busy       : sweep in progress
//   done       : one-cycle pulse after the last pad is copied
//   err        : sticky, set by a write to a pad index >= N_PADS
//   rd_addr    : readback pad index
//   rd_data    : registered active config of rd_addr (0 when out of range)
//   cfg_active : per-pad active config, pad i at [CFG_W*i +: CFG_W]
module tt_gpio_cfg_seq #(
  parameter int unsigned N_PADS = 44,
  parameter int unsigned CFG_W  = 16,
  parameter logic [N_PADS*CFG_W-1:0] DEFAULT_CONFIG = {N_PADS{CFG_W'(1)}},
  localparam int unsigned AW = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  tt_gpio_cfg_seq_if.slave          wr,
  input  logic                      commit,
  input  logic                      revert,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic [AW-1:0]             rd_addr,
  output logic [CFG_W-1:0]          rd_data,
  output logic [N_PADS*CFG_W-1:0]   cfg_active
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [AW:0]   NPADS_W  = (AW+1)'(N_PADS);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_PADS - 1);

  state_t           r_state;
  logic [AW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [CFG_W-1:0] r_rd_data;
  logic [CFG_W-1:0] r_shadow [N_PADS];
  logic [CFG_W-1:0] r_active [N_PADS];

  logic             w_wr_ready;
  logic             w_wr_fire;
  logic             w_wr_in_range;
  logic             w_rd_in_range;

  // Revert owns the shadow bank for its cycle, so writes are held off then.
  assign w_wr_ready    = (r_state == S_IDLE) && !revert;
  assign w_wr_fire     = wr.wr_valid && w_wr_ready;
  assign w_wr_in_range = ({1'b0, wr.wr_addr} < NPADS_W);
  assign w_rd_in_range = ({1'b0, rd_addr} < NPADS_W);

  assign wr.wr_ready = w_wr_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign rd_data     = r_rd_data;

  for (genvar g = 0; g < N_PADS; g++) begin : g_flat
    assign cfg_active[CFG_W*g +: CFG_W] = r_active[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_data <= '0;
      for (int unsigned i = 0; i < N_PADS; i++) begin
        r_shadow[i] <= DEFAULT_CONFIG[CFG_W*i +: CFG_W];
        r_active[i] <= DEFAULT_CONFIG[CFG_W*i +: CFG_W];
      end
    end else begin
      r_done    <= 1'b0;
      r_rd_data <= w_rd_in_range ? r_active[rd_addr] : '0;

      case (r_state)
        S_IDLE: begin
          // Shadow is updated at the commit edge, so a coincident write or
          // revert is already in place when the sweep reads entry 0.
          if (revert) begin
            for (int unsigned i = 0; i < N_PADS; i++) begin
              r_shadow[i] <= DEFAULT_CONFIG[CFG_W*i +: CFG_W];
            end
          end else if (w_wr_fire) begin
            if (wr.wr_all) begin
              for (int unsigned i = 0; i < N_PADS; i++) begin
                r_shadow[i] <= wr.wr_data;
              end
            end else if (w_wr_in_range) begin
              r_shadow[wr.wr_addr] <= wr.wr_data;
            end else begin
              r_err <= 1'b1;
            end
          end

          if (commit) begin
            r_state <= S_COMMIT;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end

        S_COMMIT: begin
          r_active[r_idx] <= r_shadow[r_idx];
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_gpio_cfg_seq.sv
// Directed self-checking bench for tt_gpio_cfg_seq (N_PADS=44, CFG_W=16).
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// the same point, i.e. they show the state left by the preceding edge.
// "Edge eN" below is the N-th rising edge after the commit cycle T began;
// edge e1 ends cycle T.
module tb_tt_gpio_cfg_seq;

  localparam int NP = 44;
  localparam int CW = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               commit;
  logic               revert;
  logic               busy;
  logic               done_o;
  logic               err;
  logic [5:0]         rd_addr;
  logic [CW-1:0]      rd_data;
  logic [NP*CW-1:0]   cfg_active;

  int n_checks = 0;
  int n_fail   = 0;

  logic [CW-1:0] exp_act [NP];

  tt_gpio_cfg_seq_if #(.AW(6), .CFG_W(CW)) wr_if ();

  tt_gpio_cfg_seq #(.N_PADS(NP), .CFG_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr_if),
    .commit     (commit),
    .revert     (revert),
    .busy       (busy),
    .done       (done_o),
    .err        (err),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cfg_active (cfg_active)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [NP*CW-1:0] flat_exp();
    logic [NP*CW-1:0] r;
    for (int i = 0; i < NP; i++) r[CW*i +: CW] = exp_act[i];
    return r;
  endfunction

  function automatic logic [CW-1:0] pad(input int k);
    return cfg_active[CW*k +: CW];
  endfunction

  task automatic test_reset();
    logic [NP*CW-1:0] dflt;
    for (int i = 0; i < NP; i++) dflt[CW*i +: CW] = 16'h0001;
    rst = 1'b1;
    step(2);
    n_checks++;
    if (cfg_active !== dflt) begin
      n_fail++;
      $display("FAIL reset_cfg_active: got %h expected all 0001", cfg_active);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++;
    if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_o); end
    n_checks++;
    if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
    n_checks++;
    if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b expected 1", wr_if.wr_ready); end
    rst = 1'b0;
    for (int i = 0; i < NP; i++) exp_act[i] = 16'h0001;
  endtask

  task automatic test_single_commit();
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = 6'd24;
    wr_if.wr_data  = 16'h6406;
    n_checks++;
    if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL single_wr_ready: got %b expected 1", wr_if.wr_ready); end
    step(1);
    wr_if.wr_valid = 1'b0;
    n_checks++;
    if (pad(24) !== 16'h0001) begin n_fail++; $display("FAIL single_shadow_only: pad24 got %h expected 0001", pad(24)); end
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    // Now just after e1; pad 24 becomes visible after e26.
    for (int c = 1; c <= 46; c++) begin
      n_checks++;
      if (busy !== (c <= 44)) begin n_fail++; $display("FAIL single_busy c=%0d: got %b expected %b", c, busy, (c <= 44)); end
      n_checks++;
      if (done_o !== (c == 45)) begin n_fail++; $display("FAIL single_done c=%0d: got %b expected %b", c, done_o, (c == 45)); end
      n_checks++;
      if (pad(24) !== ((c >= 26) ? 16'h6406 : 16'h0001)) begin
        n_fail++;
        $display("FAIL single_pad24 c=%0d: got %h expected %h", c, pad(24), (c >= 26) ? 16'h6406 : 16'h0001);
      end
      step(1);
    end
    exp_act[24] = 16'h6406;
    n_checks++;
    if (cfg_active !== flat_exp()) begin n_fail++; $display("FAIL single_all: got %h expected %h", cfg_active, flat_exp()); end
    rd_addr = 6'd24;
    step(1);
    n_checks++;
    if (rd_data !== 16'h6406) begin n_fail++; $display("FAIL single_rd24: got %h expected 6406", rd_data); end
    rd_addr = 6'd43;
    step(1);
    n_checks++;
    if (rd_data !== 16'h0001) begin n_fail++; $display("FAIL single_rd43: got %h expected 0001", rd_data); end
    rd_addr = 6'd50;
    step(1);
    n_checks++;
    if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL single_rd50: got %h expected 0000", rd_data); end
  endtask

  task automatic test_broadcast();
    wr_if.wr_valid = 1'b1;
    wr_if.wr_all   = 1'b1;
    wr_if.wr_addr  = 6'd3;
    wr_if.wr_data  = 16'h8200;
    step(1);
    wr_if.wr_valid = 1'b0;
    wr_if.wr_all   = 1'b0;
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      if (c >= 2 && c - 2 < NP) exp_act[c-2] = 16'h8200;
      n_checks++;
      if (cfg_active !== flat_exp()) begin
        n_fail++;
        $display("FAIL bcast_order c=%0d: got %h expected %h", c, cfg_active, flat_exp());
      end
      step(1);
    end
  endtask

  task automatic test_stall();
    commit = 1'b1;
    step(1);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = 6'd5;
    wr_if.wr_data  = 16'h1234;
    for (int c = 1; c <= 45; c++) begin
      n_checks++;
      if (wr_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL stall_wr_ready c=%0d: got %b expected 0", c, wr_if.wr_ready); end
      n_checks++;
      if (busy !== (c <= 44)) begin n_fail++; $display("FAIL stall_busy c=%0d: got %b expected %b", c, busy, (c <= 44)); end
      n_checks++;
      if (done_o !== (c == 45)) begin n_fail++; $display("FAIL stall_done c=%0d: got %b expected %b", c, done_o, (c == 45)); end
      if (c == 45) commit = 1'b0;
      step(1);
    end
    // First IDLE cycle: the held write is accepted at the next edge.
    n_checks++;
    if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL stall_idle_ready: got %b expected 1", wr_if.wr_ready); end
    step(1);
    wr_if.wr_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (busy !== 1'b0 || done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_no_resweep c=%0d: busy=%b done=%b expected 0/0", c, busy, done_o);
      end
      step(1);
    end
    n_checks++;
    if (pad(5) !== 16'h8200) begin n_fail++; $display("FAIL stall_active_held: pad5 got %h expected 8200", pad(5)); end
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    step(45);
    exp_act[5] = 16'h1234;
    n_checks++;
    if (cfg_active !== flat_exp()) begin n_fail++; $display("FAIL stall_landed: got %h expected %h", cfg_active, flat_exp()); end
  endtask

  task automatic test_error();
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = 6'd50;
    wr_if.wr_data  = 16'hFFFF;
    n_checks++;
    if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL err_handshake: wr_ready got %b expected 1", wr_if.wr_ready); end
    step(1);
    wr_if.wr_valid = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err); end
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    step(45);
    n_checks++;
    if (cfg_active !== flat_exp()) begin n_fail++; $display("FAIL err_shadow_unchanged: got %h expected %h", cfg_active, flat_exp()); end
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_revert();
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = 6'd7;
    wr_if.wr_data  = 16'h7777;
    step(1);
    wr_if.wr_addr  = 6'd9;
    wr_if.wr_data  = 16'h9999;
    revert = 1'b1;
    commit = 1'b1;
    #1;
    n_checks++;
    if (wr_if.wr_ready !== 1'b0) begin n_fail++; $display("FAIL revert_blocks_write: wr_ready got %b expected 0", wr_if.wr_ready); end
    step(1);
    revert = 1'b0;
    commit = 1'b0;
    wr_if.wr_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL revert_commit_busy: got %b expected 1", busy); end
    step(45);
    for (int i = 0; i < NP; i++) exp_act[i] = 16'h0001;
    n_checks++;
    if (cfg_active !== flat_exp()) begin n_fail++; $display("FAIL revert_defaults: got %h expected %h", cfg_active, flat_exp()); end
  endtask

  task automatic test_abort();
    logic [NP*CW-1:0] dflt;
    for (int i = 0; i < NP; i++) dflt[CW*i +: CW] = 16'h0001;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_all   = 1'b1;
    wr_if.wr_data  = 16'h00AA;
    step(1);
    wr_if.wr_valid = 1'b0;
    wr_if.wr_all   = 1'b0;
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    step(20);
    // After e21: pads 0..19 copied, sweep index is 20.
    n_checks++;
    if (pad(19) !== 16'h00AA || pad(20) !== 16'h0001) begin
      n_fail++;
      $display("FAIL abort_pre: pad19=%h pad20=%h expected 00aa/0001", pad(19), pad(20));
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (cfg_active !== dflt) begin n_fail++; $display("FAIL abort_cfg: got %h expected all 0001", cfg_active); end
    n_checks++;
    if (busy !== 1'b0 || done_o !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_flags: busy=%b done=%b err=%b expected 0/0/0", busy, done_o, err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = 6'd0;
    wr_if.wr_data  = 16'h5555;
    n_checks++;
    if (wr_if.wr_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", wr_if.wr_ready); end
    step(1);
    wr_if.wr_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      n_checks++;
      if (busy !== 1'b0 || done_o !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done c=%0d: busy=%b done=%b expected 0/0", c, busy, done_o);
      end
      step(1);
    end
    commit = 1'b1;
    step(1);
    commit = 1'b0;
    step(45);
    for (int i = 0; i < NP; i++) exp_act[i] = 16'h0001;
    exp_act[0] = 16'h5555;
    n_checks++;
    if (cfg_active !== flat_exp()) begin n_fail++; $display("FAIL abort_first_write: got %h expected %h", cfg_active, flat_exp()); end
  endtask

  initial begin
    rst            = 1'b1;
    commit         = 1'b0;
    revert         = 1'b0;
    rd_addr        = '0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr  = '0;
    wr_if.wr_all   = 1'b0;
    wr_if.wr_data  = '0;
    #1;
    test_reset();
    test_single_commit();
    test_broadcast();
    test_stall();
    test_error();
    test_revert();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_gpio_cfg_seq.md
TT_GPIO_CFG_SEQ -- requirements
Module: tt_gpio_cfg_seq

Interface
REQ-001 SHALL have parameter N_PADS, default 44: number of pads configured.
REQ-002 SHALL have parameter CFG_W, default 16: config word width per pad.
REQ-003 SHALL have parameter DEFAULT_CONFIG, width N_PADS*CFG_W, default 16'h0001 replicated: reset/revert config, pad i at bits [CFG_W*i +: CFG_W].
REQ-004 SHALL have derived localparam AW = max(1, clog2(N_PADS)).
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset; one clock, reset asynchronous and active-high.
REQ-007 SHALL have port wr_valid  in  1  shadow write request.
REQ-008 SHALL have port wr_ready  out  1  write accepted when wr_valid && wr_ready.
REQ-009 SHALL have port wr_addr  in  AW  target pad index.
REQ-010 SHALL have port wr_all  in  1  broadcast: write wr_data to every shadow entry; wr_addr ignored.
REQ-011 SHALL have port wr_data  in  CFG_W  config word.
REQ-012 SHALL have port commit  in  1  start staggered shadow-to-active copy.
REQ-013 SHALL have port revert  in  1  reload shadow from DEFAULT_CONFIG.
REQ-014 SHALL have port busy  out  1  commit sweep in progress.
REQ-015 SHALL have port done  out  1  one-cycle pulse at sweep end.
REQ-016 SHALL have port err  out  1  sticky out-of-range address flag.
REQ-017 SHALL have port rd_addr  in  AW  readback pad index.
REQ-018 SHALL have port rd_data  out  CFG_W  registered active config of rd_addr; 0 if out of range.
REQ-019 SHALL have port cfg_active  out  N_PADS*CFG_W  per-pad config driving the pad cells, registered.

Function
REQ-020 SHALL hold two register banks: shadow (written by host) and active (drives cfg_active).
REQ-021 SHALL implement FSM IDLE -> COMMIT -> DONE -> IDLE.
REQ-022 SHALL drive wr_ready = (state==IDLE) && !revert; writes stall (held by host) during COMMIT and DONE.
REQ-023 SHALL on accepted write with wr_addr < N_PADS, update shadow[wr_addr] at that edge; wr_all takes priority over wr_addr.
REQ-024 SHALL on accepted non-broadcast write with wr_addr >= N_PADS, complete the handshake, leave shadow unchanged, set err (cleared only by rst).
REQ-025 SHALL on revert in IDLE load all shadow entries with DEFAULT_CONFIG in one cycle; active unchanged until commit; revert outside IDLE ignored.
REQ-026 SHALL on commit in IDLE at cycle T: enter COMMIT, index=0; in each COMMIT cycle copy shadow[index] to active[index], index++; pad k visible on cfg_active after the edge ending cycle T+1+k.
REQ-027 SHALL assert busy during cycles T+1..T+N_PADS, done during cycle T+N_PADS+1 only, return to IDLE at T+N_PADS+2.
REQ-028 SHALL, when commit and accepted write coincide in IDLE, include that write in the sweep; commit with revert: revert applies, then sweep copies defaults.
REQ-029 SHALL ignore commit while busy or in DONE (no restart, no queuing).
REQ-030 SHALL update rd_data one cycle after rd_addr, reflecting active contents as of that edge.
REQ-031 SHALL never change any active entry outside a COMMIT cycle for that index.

Reset
REQ-032 SHALL on rst, asynchronously: shadow and active = DEFAULT_CONFIG, state IDLE, index 0, busy 0, done 0, err 0, rd_data 0.
REQ-033 SHALL abort a sweep in progress on rst; partially copied entries revert to DEFAULT_CONFIG.
REQ-034 SHALL, after rst deasserts, accept a write on the first rising edge.

Verification (N_PADS=44, CFG_W=16)
REQ-035 SHALL verify reset: rst pulse -> every cfg_active word 16'h0001, busy=0, err=0, wr_ready=1.
REQ-036 SHALL verify single commit: write pad 24 = 16'h6406, commit at T -> pad 24 changes after edge ending T+25, busy high 44 cycles, done only at T+45, rd_addr=24 returns 16'h6406.
REQ-037 SHALL verify broadcast: wr_all with 16'h8200, commit -> all 44 pads 16'h8200 in index order, one per cycle.
REQ-038 SHALL verify stall: wr_valid and commit held during sweep -> wr_ready=0, no second sweep, write lands in the first IDLE cycle.
REQ-039 SHALL verify error: write to wr_addr=50 -> handshake completes, shadow unchanged, err=1 until rst.
REQ-040 SHALL verify abort: rst at sweep index 20 -> all pads 16'h0001 immediately, busy=0, no done pulse.
